// File: rtl/conv3x3_scan_ctrl.sv
// conv3x3_scan_ctrl: frame sequencer for the 3x3 convolution datapath.
// Accepts a raster pixel stream, drives line-buffer/window shifting, and
// issues one output slot per pixel in raster order with coordinates, a
// border flag (datapath forces a zero result) and a last-slot marker.
// The window lags the input by one row plus one pixel, so the final
// WIDTH+1 slots are drained after the last input pixel has been accepted.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready never depends on in_valid. out_valid does not depend
// on out_ready, and a valid slot holds out_x/out_y/out_border/out_last
// stable until it is accepted.
module conv3x3_scan_ctrl #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int XW     = 5,
  parameter int YW     = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          lb_shift,
  output logic [XW-1:0] lb_col,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          out_border,
  output logic          out_last
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int NW   = $clog2(NPIX);

  localparam logic [NW-1:0] N_LAST        = NW'(NPIX - 1);
  localparam logic [NW-1:0] N_FIRST_ISSUE = NW'(WIDTH + 1);
  localparam logic [NW-1:0] N_ONE         = NW'(1);
  localparam logic [XW-1:0] X_LAST        = XW'(WIDTH - 1);
  localparam logic [XW-1:0] X_ONE         = XW'(1);
  localparam logic [YW-1:0] Y_LAST        = YW'(HEIGHT - 1);
  localparam logic [YW-1:0] Y_ONE         = YW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Input side: accepted-pixel count and raster position of the next pixel.
  logic [NW-1:0] n_q;
  logic [XW-1:0] in_x_q;
  logic [YW-1:0] in_y_q;

  // Output side: index and raster position of the next slot to load.
  logic [NW-1:0] k_q;
  logic [XW-1:0] kx_q;
  logic [YW-1:0] ky_q;

  logic slot_free;
  logic accept;
  logic load;
  logic clear;
  logic next_border;

  // The output register can take a new slot when empty or being drained now.
  assign slot_free = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign lb_shift  = accept;
  assign lb_col    = in_x_q;
  assign busy      = (state_q != S_IDLE);

  assign next_border = (ky_q == '0) || (ky_q == Y_LAST) ||
                       (kx_q == '0) || (kx_q == X_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode plus the per-cycle strobes (ready, load, done, clear).
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    load     = 1'b0;
    done     = 1'b0;
    clear    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        in_ready = slot_free;
        if (in_valid && slot_free) begin
          // Slot k is issued together with input k+WIDTH+1 so the 3x3
          // window is centred on it.
          if (n_q >= N_FIRST_ISSUE) load = 1'b1;
          if ((in_x_q == X_LAST) && (in_y_q == Y_LAST)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (slot_free) begin
          load = 1'b1;
          if (k_q == N_LAST) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (out_valid && out_ready) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Input counters: count accepted pixels and walk the raster position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q    <= '0;
      in_x_q <= '0;
      in_y_q <= '0;
    end else if (clear) begin
      n_q    <= '0;
      in_x_q <= '0;
      in_y_q <= '0;
    end else if (accept) begin
      n_q <= n_q + N_ONE;
      if (in_x_q == X_LAST) begin
        in_x_q <= '0;
        in_y_q <= in_y_q + Y_ONE;
      end else begin
        in_x_q <= in_x_q + X_ONE;
      end
    end
  end

  // Output index counters: coordinates tracked incrementally, no divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q  <= '0;
      kx_q <= '0;
      ky_q <= '0;
    end else if (clear) begin
      k_q  <= '0;
      kx_q <= '0;
      ky_q <= '0;
    end else if (load) begin
      k_q <= k_q + N_ONE;
      if (kx_q == X_LAST) begin
        kx_q <= '0;
        ky_q <= ky_q + Y_ONE;
      end else begin
        kx_q <= kx_q + X_ONE;
      end
    end
  end

  // Output slot register: reload whenever free; hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_border <= 1'b0;
      out_last   <= 1'b0;
    end else if (slot_free) begin
      out_valid <= load;
      if (load) begin
        out_x      <= kx_q;
        out_y      <= ky_q;
        out_border <= next_border;
        out_last   <= (k_q == N_LAST);
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_scan_ctrl.sv
// tb_conv3x3_scan_ctrl: self-checking bench for conv3x3_scan_ctrl on a
// non-square 6x5 frame. Expected slots are derived from the accepted pixel
// index (k = accept - WIDTH - 1) with div/mod, queued on accept and
// popped when the DUT hands a slot downstream.
module tb_conv3x3_scan_ctrl;

  localparam int W    = 6;
  localparam int H    = 5;
  localparam int XW   = 3;
  localparam int YW   = 3;
  localparam int SW   = XW + YW + 2;
  localparam int NPIX = W * H;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic          busy, done, in_ready, lb_shift, out_valid;
  logic          out_border, out_last;
  logic [XW-1:0] lb_col, out_x;
  logic [YW-1:0] out_y;

  conv3x3_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lb_shift  (lb_shift),
    .lb_col    (lb_col),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_border(out_border),
    .out_last  (out_last)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [SW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference slot encoding {x, y, border, last} from the raster index.
  function automatic logic [SW-1:0] exp_slot(input int k);
    int  x, y;
    logic brd, lst;
    x   = k % W;
    y   = k / W;
    brd = (x == 0) || (x == W - 1) || (y == 0) || (y == H - 1);
    lst = (k == NPIX - 1);
    return {XW'(x), YW'(y), brd, lst};
  endfunction

  // ---------------- driver ----------------
  bit         drv_en = 1'b0;
  bit         bursty = 1'b0;
  bit         bp = 1'b0;
  int         ph = 0;
  logic [3:0] bp_pat = 4'b1001;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (drv_en) begin
        in_valid  = bursty ? 1'($urandom_range(0, 1)) : 1'b1;
        out_ready = bp ? bp_pat[ph % 4] : 1'b1;
        ph        = ph + 1;
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int            cyc = 0;
  int            acc_n = 0;
  int            slot_cnt = 0;
  int            border_cnt = 0;
  int            done_cnt = 0;
  int            issue_cyc = -100;
  int            first_cyc = -200;
  bit            seen_first = 1'b0;
  bit            prev_stall = 1'b0;
  logic [SW-1:0] held;
  logic [SW-1:0] e;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'(1));
        check("hold_slot", 32'({out_x, out_y, out_border, out_last}), 32'(held));
      end
      prev_stall = 1'b0;
      if (out_valid && !out_ready) begin
        check("stall_in_ready", 32'(in_ready), 32'(0));
        held       = {out_x, out_y, out_border, out_last};
        prev_stall = 1'b1;
      end
      if (lb_shift) begin
        check("lb_col", 32'(lb_col), 32'(acc_n % W));
        if (acc_n == W + 1) issue_cyc = cyc;
        if (acc_n >= W + 1) exp_q.push_back(exp_slot(acc_n - W - 1));
        if (acc_n == NPIX - 1)
          for (int k = NPIX - W - 1; k < NPIX; k++) exp_q.push_back(exp_slot(k));
        acc_n = acc_n + 1;
      end
      if (out_valid && !seen_first) begin
        seen_first = 1'b1;
        first_cyc  = cyc;
      end
      if (out_valid && out_ready) begin
        slot_cnt   = slot_cnt + 1;
        border_cnt = border_cnt + 32'(out_border);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_slot: got x=%0d y=%0d required none", out_x, out_y);
        end else begin
          e = exp_q.pop_front();
          check("slot", 32'({out_x, out_y, out_border, out_last}), 32'(e));
        end
      end
      if (done) done_cnt = done_cnt + 1;
    end
  end

  // ---------------- scenario table ----------------
  typedef struct {
    bit bursty;
    bit bp;
    bit poke;
    bit coinc;
    int exp_slots;
    int exp_border;
    int exp_done;
  } scen_t;

  scen_t tbl[4];

  task automatic reset_frame_stats();
    acc_n      = 0;
    slot_cnt   = 0;
    border_cnt = 0;
    done_cnt   = 0;
    seen_first = 1'b0;
    issue_cyc  = -100;
    first_cyc  = -200;
    exp_q.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_frame(input scen_t s);
    bit got;
    reset_frame_stats();
    bursty = s.bursty;
    bp     = s.bp;
    drv_en = 1'b1;
    pulse_start();
    got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge clk);
      start = s.poke && (c == 8 || c == 20);
      if (done) begin
        got = 1'b1;
        if (s.coinc) start = 1'b1;
      end
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got no done required done within 3000 cycles");
    end
    @(posedge clk);
    #1 start = 1'b0;
    drv_en = 1'b0;
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'(0));
    repeat (3) @(negedge clk);
    check("idle_after_frame", 32'(busy), 32'(0));
    check("slot_count", 32'(slot_cnt), 32'(s.exp_slots));
    check("border_count", 32'(border_cnt), 32'(s.exp_border));
    check("done_count", 32'(done_cnt), 32'(s.exp_done));
    check("accept_count", 32'(acc_n), 32'(NPIX));
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    check("first_latency", 32'(first_cyc - issue_cyc), 32'(1));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_out_x"}, 32'(out_x), 32'(0));
    check({tag, "_out_y"}, 32'(out_y), 32'(0));
    check({tag, "_out_border"}, 32'(out_border), 32'(0));
    check({tag, "_out_last"}, 32'(out_last), 32'(0));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(0));
    check({tag, "_lb_col"}, 32'(lb_col), 32'(0));
  endtask

  // ---------------- test sequence ----------------
  localparam int EXP_BORDER = NPIX - (W - 2) * (H - 2);

  initial begin
    bit reached;
    tbl[0] = '{bursty: 1'b0, bp: 1'b0, poke: 1'b0, coinc: 1'b0,
               exp_slots: NPIX, exp_border: EXP_BORDER, exp_done: 1};
    tbl[1] = '{bursty: 1'b0, bp: 1'b1, poke: 1'b0, coinc: 1'b1,
               exp_slots: NPIX, exp_border: EXP_BORDER, exp_done: 1};
    tbl[2] = '{bursty: 1'b1, bp: 1'b0, poke: 1'b1, coinc: 1'b0,
               exp_slots: NPIX, exp_border: EXP_BORDER, exp_done: 1};
    tbl[3] = '{bursty: 1'b1, bp: 1'b1, poke: 1'b1, coinc: 1'b1,
               exp_slots: NPIX, exp_border: EXP_BORDER, exp_done: 1};

    // Reset values while rst_n is held low, before any clock edge matters.
    #2;
    check_reset_values("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Start held off with no start: controller stays idle.
    repeat (4) @(negedge clk);
    check("idle_without_start", 32'(busy), 32'(0));

    for (int i = 0; i < 4; i++) run_frame(tbl[i]);

    // Mid-frame asynchronous reset, then a clean frame must follow.
    reset_frame_stats();
    bursty = 1'b0;
    bp     = 1'b0;
    drv_en = 1'b1;
    pulse_start();
    reached = 1'b0;
    for (int c = 0; c < 500 && !reached; c++) begin
      @(negedge clk);
      if (acc_n >= 15) reached = 1'b1;
    end
    check("midframe_busy", 32'(busy), 32'(1));
    check("midframe_out_valid", 32'(out_valid), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    drv_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_rst", 32'(busy), 32'(0));
    run_frame(tbl[0]);
    run_frame(tbl[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/conv3x3_scan_ctrl.md
Name: conv3x3_scan_ctrl

Overview:
- Frame sequencer for the 3x3 convolution datapath (SobelX-style kernel, zeroed border, abs/clamp in datapath).
- Accepts a raster pixel stream and drives line-buffer/window shifting.
- Issues one output slot per pixel in raster order, with coordinates and a border flag that forces a zero result.
- Drains the tail of the frame after the last input, so the output frame is exactly WIDTH*HEIGHT pixels, matching the PGM writer.

Parameters:
- WIDTH, 32, pixels per row (>=3)
- HEIGHT, 32, rows per frame (>=3)
- XW, 5, width of column counters (>= clog2(WIDTH))
- YW, 5, width of row counters (>= clog2(HEIGHT))

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start request; sampled in IDLE only
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when the last output is accepted
- in_valid  in  1  input pixel available
- in_ready  out  1  controller can accept a pixel
- lb_shift  out  1  in_valid & in_ready; shifts line buffers/window (combinational)
- lb_col  out  XW  column of the pixel being accepted (line-buffer address)
- out_valid  out  1  output slot valid (registered)
- out_ready  in  1  downstream accepts the slot
- out_x  out  XW  output column
- out_y  out  YW  output row
- out_border  out  1  output is on the frame edge; datapath forces 0
- out_last  out  1  slot is (WIDTH-1, HEIGHT-1)

Behaviour:
- Reset (async, rst_n=0): state IDLE; all counters 0; busy=0, done=0, out_valid=0, out_x=0, out_y=0, out_border=0, out_last=0.
- Slot free: slot_free = !out_valid | out_ready. An output register holding a valid slot holds it stable until out_ready.
- FSM states: IDLE, RUN, DRAIN, FLUSH.
- IDLE:
  - in_ready=0.
  - start=1 -> RUN; clear input count n, input column/row, and output index k.
- RUN:
  - in_ready = slot_free.
  - On accept: n increments; in_x/in_y wrap raster-style; lb_col = current in_x.
  - If the accept has n >= WIDTH+1 (n taken before increment), the output register loads index k on the next edge (1-cycle latency) and k increments.
  - Accepting n = WIDTH*HEIGHT-1 -> DRAIN.
- DRAIN:
  - in_ready=0.
  - Each cycle with slot_free, load the next index k; k advances from WIDTH*HEIGHT-WIDTH-1 to WIDTH*HEIGHT-1. All WIDTH+1 of these are border slots.
  - Loading k = WIDTH*HEIGHT-1 -> FLUSH.
- FLUSH:
  - Wait for out_valid & out_ready on the out_last slot.
  - Then: done=1 for one cycle, out_valid drops, state -> IDLE.
- Output fields:
  - out_x/out_y are tracked incrementally with k (no divider).
  - out_border = (out_y==0) | (out_y==HEIGHT-1) | (out_x==0) | (out_x==WIDTH-1), registered with the slot.
  - out_last = (k == WIDTH*HEIGHT-1).
- Timing constraint: interior slot (r,c) is issued on the accept of input (r+1,c+1), so the datapath window is centred correctly.
- Simultaneous events:
  - A new slot may load in the same cycle the old slot is accepted (full throughput: 1 pixel/cycle).
  - A start asserted in the same cycle as done is ignored.
  - start in any non-IDLE state is ignored; no restart.
- Input behaviour:
  - in_valid while in_ready=0 is simply held off; no pixel loss.
  - Input counts never exceed WIDTH*HEIGHT per frame.
- Reset mid-frame:
  - Immediate return to the reset values; the partial frame is discarded.
  - The next frame needs a new start.

Test Plan:
- 4x4 frame (WIDTH=HEIGHT=4), in_valid=1, out_ready=1, start pulse:
  - First out_valid comes the cycle after the 6th accept, with (0,0), border=1.
  - 16 slots in raster order; border=0 only at (1,1),(2,1),(1,2),(2,2).
  - out_last at (3,3); done pulses once; busy low the next cycle.
- 32x32 streaming, no stalls:
  - Exactly 1024 slots: 124 border, 900 interior.
  - DRAIN emits 33 consecutive border slots.
  - Bench models the datapath (SobelX, |x| clamp 255) over a centred square image and matches the golden PGM.
- Backpressure: out_ready toggles 1,0,0,1 pattern during RUN and DRAIN:
  - out_x/out_y/out_border stay stable while stalled.
  - in_ready=0 whenever out_valid & !out_ready.
  - Slot count and order are unchanged.
- Bursty input (in_valid random 50%), out_ready=1:
  - No slot is issued without a matching accept in RUN.
  - lb_col follows 0..WIDTH-1 wrap.
- start re-asserted while busy, plus start coincident with done:
  - Both ignored; a frame only begins on a start seen in IDLE.
- rst_n pulled low after 500 accepts of a 32x32 frame:
  - All outputs go to reset values asynchronously.
  - A subsequent start runs a full, correct 1024-slot frame.
